// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, default widths and shift direction constants for the PUF datapath
package puf_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  localparam int PUF_RESP_W = 8;
  localparam logic SHIFT_LEFT = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;
endpackage

// File: rtl/puf_bit_counter.sv
// puf_bit_counter: saturating fill counter; clear and increment together yield one (first bit of next word)
module puf_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [CNT_W-1:0] count_nxt;
  assign full = count == CNT_W'(WIDTH);
  // next count: clear wins over hold, increment stops at WIDTH
  always_comb begin
    count_nxt = clr ? (inc ? CNT_W'(1) : '0) : (inc && !full ? count + CNT_W'(1) : count);
  end
  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else count <= count_nxt;
  end
endmodule

// File: rtl/puf_shift_unit.sv
// puf_shift_unit: serial-in/parallel-out and parallel-in/serial-out shift register with valid/ready word handoff
// Right shifts and shift_dir are only honoured when PUF_SHIFT_BIDIR_EN is defined; otherwise all shifts are left.
module puf_shift_unit
  import puf_pkg::*;
#(
  parameter int               WIDTH     = PUF_RESP_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             shift_en,
  input  logic             ser_in,
  input  logic             shift_dir,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] q;
  logic hs, do_shift, dir_right, full;
`ifdef PUF_SHIFT_BIDIR_EN
  assign dir_right = shift_dir == SHIFT_RIGHT;
  assign ser_out = dir_right ? q[0] : q[WIDTH-1];
`else
  assign dir_right = 1'b0;
  assign ser_out = q[WIDTH-1];
`endif
  assign hs = out_valid && out_ready;
  assign do_shift = !load && shift_en && (state != FULL || hs);
  assign par_out = q;
  puf_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(load || hs), .inc(do_shift), .count(count), .full(full)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: load beats handshake beats shift; a shift during handshake starts the next word
  always_comb begin
    state_nxt = load ? IDLE
              : hs ? (shift_en ? FILL : IDLE)
              : do_shift ? (count == CNT_W'(WIDTH - 1) ? FULL : FILL)
              : state;
  end
  // output decode
  always_comb begin
    out_valid = state == FULL;
  end
  // data register: parallel load or one-bit shift, else hold (including the FULL stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VAL;
    else if (load) q <= par_in;
    else if (do_shift) q <= dir_right ? {ser_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], ser_in};
  end
endmodule
